// File: rtl/pipelined_prefix_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_prefix_subtractor
// Description : Pipelined z = x - y - borrow_in using a Kogge-Stone borrow
//               prefix tree, one registered tree level per stage, with a
//               valid/ready handshake that stalls the whole pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_prefix_subtractor #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 2**LEVELS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    // The pipeline moves as a single unit: any held result freezes every stage.
    logic w_stall;

    // Per-stage state: index 0 is the capture stage, index LEVELS the last tree level.
    logic             r_v  [0:LEVELS];
    logic [WIDTH-1:0] r_g  [0:LEVELS];
    logic [WIDTH-1:0] r_p  [0:LEVELS];
    logic [WIDTH-1:0] r_d  [0:LEVELS];
    logic             r_xs [0:LEVELS];
    logic             r_ys [0:LEVELS];
    logic             r_bi [0:LEVELS];

    // Capture-stage borrow signals.
    logic [WIDTH-1:0] w_bg;
    logic [WIDTH-1:0] w_bp;
    logic [WIDTH-1:0] w_g0;

    // Next values for each tree level.
    logic [WIDTH-1:0] w_g_nxt [1:LEVELS];
    logic [WIDTH-1:0] w_p_nxt [1:LEVELS];

    // Output-stage signals.
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_z;
    logic             w_ovf;

    // Output registers.
    logic             r_out_valid;
    logic [WIDTH-1:0] r_z;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_zero;

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // Bit-level borrow generate/propagate; borrow_in folds into bit 0 so the
    // tree never needs a separate carry-in path.
    assign w_bg = ~x & y;
    assign w_bp = ~(x ^ y);
    assign w_g0 = {w_bg[WIDTH-1:1], w_bg[0] | (w_bp[0] & borrow_in)};

    // Kogge-Stone combine at span 2**(k-1); bits below the span pass through.
    always_comb begin
        for (int k = 1; k <= LEVELS; k++) begin
            w_g_nxt[k] = r_g[k-1];
            w_p_nxt[k] = r_p[k-1];
            for (int i = (1 << (k-1)); i < WIDTH; i++) begin
                w_g_nxt[k][i] = r_g[k-1][i] | (r_p[k-1][i] & r_g[k-1][i-(1 << (k-1))]);
                w_p_nxt[k][i] = r_p[k-1][i] & r_p[k-1][i-(1 << (k-1))];
            end
        end
    end

    // Stage valid bits: cleared by reset, shifted whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LEVELS; k++) begin
                r_v[k] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_v[0] <= in_valid & in_ready;
            for (int k = 1; k <= LEVELS; k++) begin
                r_v[k] <= r_v[k-1];
            end
        end
    end

    // Stage data: no reset needed since the valid bits gate everything downstream.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_g[0]  <= w_g0;
            r_p[0]  <= w_bp;
            r_d[0]  <= x ^ y;
            r_xs[0] <= x[WIDTH-1];
            r_ys[0] <= y[WIDTH-1];
            r_bi[0] <= borrow_in;
            for (int k = 1; k <= LEVELS; k++) begin
                r_g[k]  <= w_g_nxt[k];
                r_p[k]  <= w_p_nxt[k];
                r_d[k]  <= r_d[k-1];
                r_xs[k] <= r_xs[k-1];
                r_ys[k] <= r_ys[k-1];
                r_bi[k] <= r_bi[k-1];
            end
        end
    end

    // Borrow into bit i is the group borrow of bits [i-1:0]; bit 0 sees borrow_in.
    assign w_b   = {r_g[LEVELS][WIDTH-2:0], r_bi[LEVELS]};
    assign w_z   = r_d[LEVELS] ^ w_b;
    assign w_ovf = (r_xs[LEVELS] != r_ys[LEVELS]) & (w_z[WIDTH-1] != r_xs[LEVELS]);

    // Output registers: result fields only load on a valid token so bubbles
    // never expose stale stage data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_z          <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_v[LEVELS];
            if (r_v[LEVELS]) begin
                r_z          <= w_z;
                r_borrow_out <= r_g[LEVELS][WIDTH-1];
                r_overflow   <= w_ovf;
                r_zero       <= (w_z == '0);
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign z          = r_z;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;
    assign zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_prefix_subtractor
// Description : Self-checking bench for pipelined_prefix_subtractor: directed
//               edge cases, a stalled stream, random traffic against an
//               arithmetic reference model, and reset with work in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_prefix_subtractor;

    localparam int LEVELS = 3;
    localparam int WIDTH  = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    int          n_checks;
    int          n_errors;
    int          n_out;
    logic [10:0] q[$];
    logic        prev_stall;
    logic [11:0] snap;

    pipelined_prefix_subtractor #(.LEVELS(LEVELS), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .z          (z),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference result {z, borrow_out, overflow, zero} from plain integer arithmetic.
    function automatic logic [10:0] model(logic [7:0] a, logic [7:0] b, logic c);
        int         diff;
        int         sdiff;
        logic [7:0] zz;
        logic       bo;
        logic       ov;
        diff  = int'(a) - int'(b) - int'(c);
        sdiff = int'($signed(a)) - int'($signed(b)) - int'(c);
        zz    = diff[7:0];
        bo    = (diff < 0);
        ov    = (sdiff < -128) || (sdiff > 127);
        return {zz, bo, ov, (zz == 8'd0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One handshake cycle: inputs are already set for this cycle on entry.
    task automatic tick(output logic acc);
        logic [10:0] exp_r;
        #1;
        check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (prev_stall)
            check("hold", 32'({out_valid, z, borrow_out, overflow, zero}), 32'(snap));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("extra_result", 32'(out_valid), 32'(0));
            end else begin
                exp_r = q.pop_front();
                check("result", 32'({z, borrow_out, overflow, zero}), 32'(exp_r));
                n_out++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(x, y, borrow_in));
        prev_stall = out_valid && !out_ready;
        snap       = {out_valid, z, borrow_out, overflow, zero};
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single isolated operation: checks latency, fields and one-cycle valid.
    task automatic single(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [10:0] exp_r);
        int n;
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        borrow_in = c;
        out_ready = 1'b1;
        #1;
        check("accept_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", 32'(n), 32'(LEVELS + 2));
        check("single_const", 32'({z, borrow_out, overflow, zero}), 32'(exp_r));
        check("single_model", 32'({z, borrow_out, overflow, zero}), 32'(model(a, b, c)));
        @(posedge clk);
        @(negedge clk);
        #1;
        check("one_shot", 32'(out_valid), 32'(0));
    endtask

    initial begin
        logic acc;
        int   idx;
        int   cyc;
        int   stalls;
        int   base;
        int   n_acc;
        logic pend;

        n_checks   = 0;
        n_errors   = 0;
        n_out      = 0;
        prev_stall = 1'b0;
        snap       = '0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        x          = '0;
        y          = '0;
        borrow_in  = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", 32'({out_valid, z, borrow_out, overflow, zero}), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));

        // Directed edge cases.
        single(8'h35, 8'h12, 1'b0, {8'h23, 1'b0, 1'b0, 1'b0});
        single(8'h00, 8'h01, 1'b0, {8'hFF, 1'b1, 1'b0, 1'b0});
        single(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1, 1'b0});
        single(8'h10, 8'h0F, 1'b1, {8'h00, 1'b0, 1'b0, 1'b1});
        single(8'hAA, 8'hAA, 1'b1, {8'hFF, 1'b1, 1'b0, 1'b0});
        single(8'h00, 8'hFF, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});

        // Back-to-back stream with a 3-cycle consumer stall mid-stream.
        prev_stall = 1'b0;
        idx    = 0;
        stalls = 0;
        base   = n_out;
        for (cyc = 0; cyc < 60 && (idx < 8 || q.size() > 0); cyc++) begin
            in_valid  = (idx < 8);
            x         = 8'(idx * 8'h11);
            y         = 8'(idx);
            borrow_in = 1'b0;
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (out_valid && !out_ready) stalls++;
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stream_stalls", 32'(stalls), 32'(3));
        check("stream_count", 32'(n_out - base), 32'(8));

        // Random traffic; producer holds an operand until it is accepted.
        prev_stall = 1'b0;
        n_acc = 0;
        pend  = 1'b0;
        for (cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                x         = 8'($urandom);
                y         = 8'($urandom);
                borrow_in = 1'($urandom);
                pend      = 1'b1;
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
            if (acc) begin
                pend = 1'b0;
                n_acc++;
            end
        end
        check("random_accepted", 32'(n_acc), 32'(1000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 20 && q.size() > 0; cyc++) tick(acc);
        check("random_drained", 32'(q.size()), 32'(0));

        // Reset with three operations in flight: none may ever emerge.
        prev_stall = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            x         = 8'($urandom);
            y         = 8'($urandom);
            borrow_in = 1'b0;
            tick(acc);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_flight_outputs", 32'({out_valid, z, borrow_out, overflow, zero}), 32'(0));
        check("rst_flight_ready", 32'(in_ready), 32'(1));
        q.delete();
        prev_stall = 1'b0;
        for (int i = 0; i < 10; i++) tick(acc);
        single(8'h5C, 8'h21, 1'b1, {8'h3A, 1'b0, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
